// File: rtl/ecp8e_io_endpoint.sv
// ECP8e architectural I/O endpoint: CPU-facing TX/RX byte FIFOs with a host valid/ready side.
// Optional feature macro: ECP8E_IO_LOOPBACK_EN (adds `loopback`, routing CPU writes into RX).
module ecp8e_io_endpoint #(
  parameter int         DEPTH           = 4,
  parameter logic [7:0] UNDERFLOW_VALUE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arch_output_enable,
  input  logic [7:0]               arch_output_value,
  input  logic                     arch_input_enable,
  output logic [7:0]               arch_input_value,
  output logic                     host_tx_valid,
  output logic [7:0]               host_tx_data,
  input  logic                     host_tx_ready,
  input  logic                     host_rx_valid,
  input  logic [7:0]               host_rx_data,
  output logic                     host_rx_ready,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     err_overflow,
  output logic                     err_underflow,
`ifdef ECP8E_IO_LOOPBACK_EN
  input  logic                     loopback,
`endif
  input  logic                     err_clear
);
  // Handshakes: a transfer completes on a rising edge where valid && ready are both
  // high; ready/valid on the host side decode from registered counts only.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;

  logic lb;
`ifdef ECP8E_IO_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  logic tx_full, rx_full, rx_empty;
  logic tx_pop, tx_push_req, tx_push;
  logic rx_pop, lb_push_req, host_push, rx_push;
  logic ovf_set, unf_set;
  logic [7:0] rx_push_data;

  assign tx_full  = (tx_count == FULL);
  assign rx_full  = (rx_count == FULL);
  assign rx_empty = (rx_count == '0);

  assign host_tx_valid = (tx_count != '0);
  assign host_rx_ready = !rx_full && !lb;
  assign host_tx_data  = tx_mem[tx_rd];
  assign arch_input_value = rx_empty ? UNDERFLOW_VALUE : rx_mem[rx_rd];

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign tx_pop      = host_tx_valid && host_tx_ready;
  assign tx_push_req = arch_output_enable && !lb;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  assign rx_pop      = arch_input_enable && !rx_empty;
  assign lb_push_req = arch_output_enable && lb;
  assign host_push   = host_rx_valid && host_rx_ready;
  assign rx_push     = host_push || (lb_push_req && (!rx_full || rx_pop));
  assign rx_push_data = lb ? arch_output_value : host_rx_data;

  assign ovf_set = (tx_push_req && tx_full && !tx_pop) ||
                   (lb_push_req && rx_full && !rx_pop);
  assign unf_set = arch_input_enable && rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      tx_count      <= '0;
      rx_count      <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem[i] <= 8'h00;
        rx_mem[i] <= 8'h00;
      end
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= arch_output_value;
        tx_wr         <= tx_wr + AW'(1);
      end
      if (tx_pop) tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);

      if (rx_push) begin
        rx_mem[rx_wr] <= rx_push_data;
        rx_wr         <= rx_wr + AW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);

      // Setting wins over a clear issued in the same cycle.
      if (ovf_set)        err_overflow <= 1'b1;
      else if (err_clear) err_overflow <= 1'b0;
      if (unf_set)        err_underflow <= 1'b1;
      else if (err_clear) err_underflow <= 1'b0;
    end
  end
endmodule
